// File: rtl/store_merge_pkg.sv
// Shared types and helpers for the read-modify-write store merge unit.
package store_merge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    // Access size in bytes, never wider than one memory word.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3, input int data_w);
        logic [3:0] full;
        logic [3:0] b;
        full = 4'(data_w / 8);
        case (funct3)
            F3_SB:   b = 4'd1;
            F3_SH:   b = 4'd2;
            F3_SW:   b = 4'd4;
            F3_SD:   b = 4'd8;
            default: b = full;
        endcase
        if (b > full) b = full;
        return b;
    endfunction

endpackage

// File: rtl/store_merge_if.sv
// Request and data-memory port bundle of the store merge unit.
interface store_merge_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic              done;
    logic              misalign_err;

    modport master (
        output req_valid, req_funct3, req_addr, req_data, mem_rd_data,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misalign_err
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, mem_rd_data,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misalign_err
    );
endinterface

// File: rtl/byte_lane_merge.sv
// Combinational byte merge: replaces lanes [off, off+bytes-1] of a word with right-aligned new data.
module byte_lane_merge #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]               old_word,
    input  logic [DATA_W-1:0]               new_data,
    input  logic [$clog2(DATA_W/8)-1:0]     off,
    input  logic [3:0]                      bytes,
    output logic [DATA_W-1:0]               merged
);
    localparam int NB = DATA_W / 8;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(off) && i < int'(off) + int'(bytes))
                merged[8*i +: 8] = new_data[8*(i - int'(off)) +: 8];
        end
    end
endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store as read-modify-write against data memory.
// Optional FULL_STORE_BYPASS_EN: aligned full-width stores skip the read.
module store_merge_unit
    import store_merge_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    store_merge_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  off_q;
    logic [3:0]        bytes_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic [3:0]        req_bytes;
    logic [OFF_W-1:0]  req_off;
    logic              req_misalign;
    logic              rd_last;
    logic [DATA_W-1:0] merged;

    assign accept       = bus.req_valid && (state_q == IDLE);
    assign req_bytes    = size_bytes(bus.req_funct3, DATA_W);
    assign req_off      = bus.req_addr[OFF_W-1:0];
    // Sizes are powers of two, so off % bytes reduces to a mask test.
    assign req_misalign = |(req_off & OFF_W'(req_bytes - 4'd1));
    assign rd_last      = (state_q == WAIT) && (cnt_q == CNT_LAST);

    byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (rdata_q),
        .new_data (data_q),
        .off      (off_q),
        .bytes    (bytes_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            off_q   <= req_off;
            bytes_q <= req_bytes;
            data_q  <= bus.req_data;
        end
        if (rd_last)
            rdata_q <= bus.mem_rd_data;
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bus.req_ready    = 1'b0;
        bus.mem_rd_en    = 1'b0;
        bus.mem_wr_en    = 1'b0;
        bus.done         = 1'b0;
        bus.misalign_err = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wr_data  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (req_misalign)
                        state_d = ERR;
`ifdef FULL_STORE_BYPASS_EN
                    else if (req_bytes == 4'(NB) && req_off == '0)
                        state_d = WR;
`endif
                    else
                        state_d = RD;
                end
            end
            RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_q;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                bus.mem_addr = addr_q;
                if (rd_last)
                    state_d = WR;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            WR: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = addr_q;
                bus.mem_wr_data = merged;
                state_d         = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                bus.misalign_err = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: MEM_LAT=1 and MEM_LAT=3 instances against a mask-based store model.
module tb_store_merge_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    store_merge_if #(.DATA_W(64), .ADDR_W(64)) ifa ();
    store_merge_if #(.DATA_W(64), .ADDR_W(64)) ifb ();

    store_merge_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ifa.slave));
    store_merge_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb.slave));

    // memories with fixed read latency; junk on the bus when no read data is due
    logic [63:0] mem_a [16];
    logic [63:0] mem_b [16];
    logic [63:0] ref_a [16];
    logic        pl_en = 1'b0, pl_sel = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [63:0] pl_val = '0;
    logic [63:0] junk = '0;
    logic        va = 1'b0;
    logic [63:0] da = '0;
    logic [2:0]  vb = '0;
    logic [63:0] db [3];

    always @(posedge clk) begin
        junk  <= {$urandom, $urandom};
        va    <= ifa.mem_rd_en;
        da    <= mem_a[ifa.mem_addr[6:3]];
        vb    <= {vb[1:0], ifb.mem_rd_en};
        db[0] <= mem_b[ifb.mem_addr[6:3]];
        db[1] <= db[0];
        db[2] <= db[1];
        if (ifa.mem_wr_en) mem_a[ifa.mem_addr[6:3]] <= ifa.mem_wr_data;
        if (ifb.mem_wr_en) mem_b[ifb.mem_addr[6:3]] <= ifb.mem_wr_data;
        if (pl_en) begin
            if (pl_sel) mem_b[pl_idx] <= pl_val;
            else        mem_a[pl_idx] <= pl_val;
        end
    end
    assign ifa.mem_rd_data = va ? da : junk;
    assign ifb.mem_rd_data = vb[2] ? db[2] : junk;

    logic        sel = 1'b0;
    logic        o_rd, o_wr, o_done, o_err, o_ready;
    logic [63:0] o_wdata, o_addr;
    assign o_rd    = sel ? ifb.mem_rd_en    : ifa.mem_rd_en;
    assign o_wr    = sel ? ifb.mem_wr_en    : ifa.mem_wr_en;
    assign o_done  = sel ? ifb.done         : ifa.done;
    assign o_err   = sel ? ifb.misalign_err : ifa.misalign_err;
    assign o_ready = sel ? ifb.req_ready    : ifa.req_ready;
    assign o_wdata = sel ? ifb.mem_wr_data  : ifa.mem_wr_data;
    assign o_addr  = sel ? ifb.mem_addr     : ifa.mem_addr;

    int passed = 0;
    int total  = 0;

    int          rd_q[$], wr_q[$], done_q[$], err_q[$];
    logic [63:0] wd_q[$], wa_q[$];
    int          ready_first;
    int          overlap;
    logic [2:0]  f3_2;
    logic [63:0] addr_2, data_2;

    function automatic int ref_bytes(input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] data,
                                              input int off, input int nb);
        logic [127:0] mask;
        logic [127:0] r;
        mask = ((128'd1 << (8 * nb)) - 128'd1) << (8 * off);
        r    = ({64'd0, old} & ~mask) | (({64'd0, data} << (8 * off)) & mask);
        return r[63:0];
    endfunction

    function automatic bit ref_bypass(input logic [2:0] f3, input int off);
`ifdef FULL_STORE_BYPASS_EN
        return (ref_bytes(f3) == 8) && (off == 0);
`else
        return (f3 == f3) && (off < 0);
`endif
    endfunction

    function automatic int nth(input int q[$], input int k);
        return (k < q.size()) ? q[k] : 0;
    endfunction

    function automatic logic [63:0] nth64(input logic [63:0] q[$], input int k);
        return (k < q.size()) ? q[k] : 64'd0;
    endfunction

    task automatic drive(input logic v, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] data);
        if (sel) begin
            ifb.req_valid = v; ifb.req_funct3 = f3; ifb.req_addr = addr; ifb.req_data = data;
        end else begin
            ifa.req_valid = v; ifa.req_funct3 = f3; ifa.req_addr = addr; ifa.req_data = data;
        end
    endtask

    task automatic preload(input logic s, input logic [3:0] idx, input logic [63:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = s; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
        if (!s) ref_a[idx] = val;
    endtask

    task automatic start_req(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
        @(negedge clk);
        drive(1'b1, f3, addr, data);
    endtask

    // cycle c is the c-th cycle after the acceptance edge
    task automatic observe(input int ncyc, input int drop_at, input int switch_at);
        rd_q.delete(); wr_q.delete(); done_q.delete(); err_q.delete();
        wd_q.delete(); wa_q.delete();
        ready_first = 0;
        overlap     = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == switch_at) drive(1'b1, f3_2, addr_2, data_2);
            if (c == drop_at)   drive(1'b0, 3'd0, 64'd0, 64'd0);
            if (o_rd) rd_q.push_back(c);
            if (o_wr) begin
                wr_q.push_back(c);
                wd_q.push_back(o_wdata);
                wa_q.push_back(o_addr);
            end
            if (o_done) done_q.push_back(c);
            if (o_err)  err_q.push_back(c);
            if (o_rd && o_wr) overlap++;
            if (o_ready && ready_first == 0) ready_first = c;
        end
    endtask

    task automatic test_reset;
        logic [6:0] got;
        rst_a = 1'b1; rst_b = 1'b1;
        sel = 1'b0; drive(1'b0, 3'd0, 64'd0, 64'd0);
        sel = 1'b1; drive(1'b0, 3'd0, 64'd0, 64'd0);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        got = {ifa.req_ready, ifa.mem_rd_en, ifa.mem_wr_en, ifa.done, ifa.misalign_err,
               |ifa.mem_addr, |ifa.mem_wr_data};
        total++;
        if (got !== 7'b1000000) $display("FAIL reset_a outputs got=%b want=1000000", got);
        else passed++;
        got = {ifb.req_ready, ifb.mem_rd_en, ifb.mem_wr_en, ifb.done, ifb.misalign_err,
               |ifb.mem_addr, |ifb.mem_wr_data};
        total++;
        if (got !== 7'b1000000) $display("FAIL reset_b outputs got=%b want=1000000", got);
        else passed++;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            preload(1'b0, 4'(i), {$urandom, $urandom});
            preload(1'b1, 4'(i), {$urandom, $urandom});
        end
    endtask

    task automatic test_sb_example;
        sel = 1'b0;
        preload(1'b0, 4'd0, 64'h1122334455667788);
        start_req(3'b000, 64'h3, 64'hAB);
        observe(8, 1, 0);
        total++;
        if (nth(rd_q, 0) !== 1 || rd_q.size() != 1)
            $display("FAIL sb_rd_cycle got=%0d n=%0d want=1 n=1", nth(rd_q, 0), rd_q.size());
        else passed++;
        total++;
        if (nth(wr_q, 0) !== 3 || wr_q.size() != 1)
            $display("FAIL sb_wr_cycle got=%0d n=%0d want=3 n=1", nth(wr_q, 0), wr_q.size());
        else passed++;
        total++;
        if (nth64(wd_q, 0) !== 64'h11223344AB667788)
            $display("FAIL sb_wr_data got=%h want=11223344ab667788", nth64(wd_q, 0));
        else passed++;
        total++;
        if (nth(done_q, 0) !== 4 || ready_first !== 5)
            $display("FAIL sb_done_ready got=%0d/%0d want=4/5", nth(done_q, 0), ready_first);
        else passed++;
        ref_a[0] = 64'h11223344AB667788;
    endtask

    task automatic test_sh_example;
        sel = 1'b0;
        preload(1'b0, 4'd1, 64'hFFFFFFFFFFFFFFFF);
        start_req(3'b001, 64'hE, 64'hBEEF);
        observe(8, 1, 0);
        total++;
        if (nth64(wd_q, 0) !== 64'hBEEFFFFFFFFFFFFF)
            $display("FAIL sh_wr_data got=%h want=beefffffffffffff", nth64(wd_q, 0));
        else passed++;
        total++;
        if (nth64(wa_q, 0) !== 64'h8) $display("FAIL sh_wr_addr got=%h want=8", nth64(wa_q, 0));
        else passed++;
        ref_a[1] = 64'hBEEFFFFFFFFFFFFF;
    endtask

    task automatic test_misalign;
        sel = 1'b0;
        start_req(3'b010, 64'h2, 64'h12345678);
        observe(6, 1, 0);
        total++;
        if (nth(err_q, 0) !== 1 || err_q.size() != 1)
            $display("FAIL misalign_err got=%0d n=%0d want=1 n=1", nth(err_q, 0), err_q.size());
        else passed++;
        total++;
        if (rd_q.size() + wr_q.size() + done_q.size() != 0)
            $display("FAIL misalign_no_access got=%0d strobes want=0",
                     rd_q.size() + wr_q.size() + done_q.size());
        else passed++;
        total++;
        if (ready_first !== 2) $display("FAIL misalign_ready got=%0d want=2", ready_first);
        else passed++;
    endtask

    task automatic test_full_store;
        logic [23:0] got, want;
        sel = 1'b0;
        start_req(3'b011, 64'h10, 64'hDEADBEEFCAFEF00D);
        observe(8, 1, 0);
        got = {8'(rd_q.size() == 0 ? 0 : nth(rd_q, 0)), 8'(nth(wr_q, 0)), 8'(nth(done_q, 0))};
`ifdef FULL_STORE_BYPASS_EN
        want = {8'd0, 8'd1, 8'd2};
`else
        want = {8'd1, 8'd3, 8'd4};
`endif
        total++;
        if (got !== want) $display("FAIL sd_timing got=%h want=%h (rd,wr,done)", got, want);
        else passed++;
        total++;
        if (nth64(wd_q, 0) !== 64'hDEADBEEFCAFEF00D)
            $display("FAIL sd_wr_data got=%h want=deadbeefcafef00d", nth64(wd_q, 0));
        else passed++;
        ref_a[2] = 64'hDEADBEEFCAFEF00D;
    endtask

    task automatic test_random;
        int          idx, off, nb;
        bit          mis, byp;
        logic [2:0]  f3;
        logic [63:0] data, addr, exp_w;
        logic [39:0] got, want;
        sel = 1'b0;
        for (int n = 0; n < 40; n++) begin
            idx  = $urandom_range(0, 15);
            off  = $urandom_range(0, 7);
            f3   = 3'($urandom_range(0, 7));
            data = {$urandom, $urandom};
            addr = ({$urandom, $urandom} & ~64'h7F) | 64'(idx * 8 + off);
            nb   = ref_bytes(f3);
            mis  = (off % nb) != 0;
            byp  = !mis && ref_bypass(f3, off);
            start_req(f3, addr, data);
            observe(8, 1, 0);
            got  = {8'(nth(rd_q, 0)), 8'(nth(wr_q, 0)), 8'(nth(done_q, 0)), 8'(nth(err_q, 0)),
                    8'(ready_first)};
            if (mis)      want = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
            else if (byp) want = {8'd0, 8'd1, 8'd2, 8'd0, 8'd3};
            else          want = {8'd1, 8'd3, 8'd4, 8'd0, 8'd5};
            total++;
            if (got !== want || overlap != 0 || rd_q.size() > 1 || wr_q.size() > 1)
                $display("FAIL rand%0d_timing f3=%0d off=%0d got=%h want=%h", n, f3, off, got, want);
            else passed++;
            if (!mis) begin
                exp_w = ref_merge(ref_a[idx], data, off, nb);
                total++;
                if (nth64(wd_q, 0) !== exp_w || nth64(wa_q, 0) !== (addr & ~64'h7))
                    $display("FAIL rand%0d_write f3=%0d off=%0d got=%h@%h want=%h@%h", n, f3, off,
                             nth64(wd_q, 0), nth64(wa_q, 0), exp_w, addr & ~64'h7);
                else passed++;
                ref_a[idx] = exp_w;
            end
            total++;
            if (mem_a[idx] !== ref_a[idx])
                $display("FAIL rand%0d_mem got=%h want=%h", n, mem_a[idx], ref_a[idx]);
            else passed++;
        end
    endtask

    task automatic test_lat3_reset_mid;
        logic [63:0] exp_w;
        logic [6:0]  got;
        int          late;
        sel = 1'b1;
        preload(1'b1, 4'd4, 64'h0123456789ABCDEF);
        start_req(3'b000, 64'h20, 64'h5A);
        observe(10, 1, 0);
        exp_w = ref_merge(64'h0123456789ABCDEF, 64'h5A, 0, 1);
        total++;
        if (nth(rd_q, 0) !== 1 || nth(wr_q, 0) !== 5 || nth(done_q, 0) !== 6)
            $display("FAIL lat3_timing got=%0d/%0d/%0d want=1/5/6",
                     nth(rd_q, 0), nth(wr_q, 0), nth(done_q, 0));
        else passed++;
        total++;
        if (nth64(wd_q, 0) !== exp_w) $display("FAIL lat3_wr_data got=%h want=%h", nth64(wd_q, 0), exp_w);
        else passed++;

        preload(1'b1, 4'd6, 64'hCAFEBABE00C0FFEE);
        start_req(3'b000, 64'h30, 64'h77);
        @(negedge clk); drive(1'b0, 3'd0, 64'd0, 64'd0);
        @(negedge clk);
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        got = {ifb.req_ready, ifb.mem_rd_en, ifb.mem_wr_en, ifb.done, ifb.misalign_err,
               |ifb.mem_addr, |ifb.mem_wr_data};
        total++;
        if (got !== 7'b1000000) $display("FAIL midreset_outputs got=%b want=1000000", got);
        else passed++;
        late = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifb.mem_wr_en || ifb.done || ifb.mem_rd_en) late++;
        end
        total++;
        if (late != 0) $display("FAIL midreset_no_write got=%0d strobes want=0", late);
        else passed++;
        total++;
        if (mem_b[6] !== 64'hCAFEBABE00C0FFEE)
            $display("FAIL midreset_mem got=%h want=cafebabe00c0ffee", mem_b[6]);
        else passed++;
        sel = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] d1, e1, e2;
        logic [47:0] got;
        sel  = 1'b0;
        d1   = {$urandom, $urandom};
        f3_2 = 3'b001;
        addr_2 = 64'h2C;
        data_2 = {$urandom, $urandom};
        start_req(3'b000, 64'h29, d1);
        observe(14, 6, 1);
        e1 = ref_merge(ref_a[5], d1, 1, 1);
        e2 = ref_merge(e1, data_2, 4, 2);
        got = {8'(nth(rd_q, 0)), 8'(nth(rd_q, 1)), 8'(nth(wr_q, 0)), 8'(nth(wr_q, 1)),
               8'(nth(done_q, 0)), 8'(nth(done_q, 1))};
        total++;
        if (got !== {8'd1, 8'd6, 8'd3, 8'd8, 8'd4, 8'd9} || rd_q.size() != 2)
            $display("FAIL b2b_timing got=%h want=010603080409", got);
        else passed++;
        total++;
        if (nth64(wd_q, 0) !== e1) $display("FAIL b2b_first_data got=%h want=%h", nth64(wd_q, 0), e1);
        else passed++;
        total++;
        if (nth64(wd_q, 1) !== e2) $display("FAIL b2b_second_data got=%h want=%h", nth64(wd_q, 1), e2);
        else passed++;
        ref_a[5] = e2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sb_example();
        test_sh_example();
        test_misalign();
        test_full_store();
        test_random();
        test_lat3_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
